debug_snapshot_unit: RTL and testbench
======================================

# debug_snapshot_unit

Parametrised debug controller for the pipelined CPU. It decodes single-byte commands from the UART receiver to halt, run and single-step the pipeline, and to request dumps. On each dump it freezes a snapshot of `NUM_WORDS` debug words (register file, control bits, latched instruction, PC) and streams it as a framed byte sequence to the UART transmitter over a valid/ready handshake. This replaces fixed-width register-by-register dumping with a generic word count and a shadow capture, adds run-until-halt with pipeline drain, and adds an optional checksum.

## Interface
- `NUM_WORDS`, default 40: number of snapshot words; 1..255.
- `WORD_W`, default 32: bits per word; must be a multiple of 8.
- `DRAIN_CYCLES`, default 4: cycles `pipe_enable` stays high after `pc_enable` drops on a halt.
- `SOF`, default 8'hA5: start-of-frame byte.
- `clk`, input, 1: single clock, all logic on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `rx_data`, input, 8: received command byte.
- `rx_valid`, input, 1: one-cycle pulse; `rx_data` is valid in that cycle.
- `snap_data`, input, `NUM_WORDS*WORD_W`: flattened debug words; word 0 is in the LSBs.
- `halt_req`, input, 1: the pipeline has reached a halt instruction.
- `tx_data`, output, 8: byte offered to the transmitter.
- `tx_valid`, output, 1: `tx_data` is valid.
- `tx_ready`, input, 1: the transmitter accepts the byte.
- `pipe_enable`, output, 1: enable for the pipeline latches.
- `pc_enable`, output, 1: enable for the PC register.
- `busy`, output, 1: a frame is in progress.

## Operation
- **Commands** (all other byte values are ignored):
  - 'c' (8'h63): run.
  - 'h' (8'h68): halt.
  - 's' (8'h73): single step.
  - 'd' (8'h64): dump.
- **State machine** states: HALT, RUN, STEP, DRAIN, CAPTURE, SEND.
- **HALT**
  - 'c' goes to RUN.
  - 's' goes to STEP.
  - 'd' goes to CAPTURE.
  - 'h' is ignored.
- **RUN**
  - `pipe_enable` = `pc_enable` = 1.
  - `halt_req` or 'h' goes to DRAIN.
  - If both occur in the same cycle, the transition happens once.
- **DRAIN**
  - `pc_enable` = 0 and `pipe_enable` = 1 for `DRAIN_CYCLES` cycles, then go to CAPTURE.
  - If `DRAIN_CYCLES` = 0, go straight to CAPTURE.
- **STEP**
  - Exactly one cycle with both enables at 1, then go to CAPTURE.
  - `halt_req` does not shorten a step.
- **CAPTURE**
  - Copies `snap_data` into a shadow register in one cycle.
  - Clears the byte index and checksum, then goes to SEND.
- **SEND** emits the frame in this order:
  - `SOF`.
  - `NUM_WORDS` as an 8-bit count.
  - Each word, word 0 first, each word MSB byte first.
  - The optional checksum byte.
  - After the last byte is accepted, go to HALT.
- **Frame length** is 2 + `NUM_WORDS*WORD_W/8` bytes (+1 with checksum). For the defaults that is 162 bytes (163 with checksum).
- Command bytes received in STEP, DRAIN, CAPTURE or SEND are dropped. They are not queued.
- `busy` is 1 in CAPTURE and SEND.
- The byte index counter is `$clog2` of the frame length wide and never wraps within a frame.

## Timing
- **Reset values:**
  - State is HALT.
  - `tx_valid` = 0, `tx_data` = 0.
  - `pipe_enable` = 0, `pc_enable` = 0.
  - `busy` = 0.
  - Shadow register and checksum are 0.
- A reset asserted mid-frame or mid-drain abandons the operation immediately. No partial byte is completed.
- All outputs are registered.
- **Step latency:** 's' at cycle N gives both enables high in cycle N+1 only. Capture happens at N+2 and `tx_valid` with `SOF` rises at N+3.
- **Run latency:** 'c' at cycle N gives enables high from cycle N+1.
- **Halt latency:** `halt_req` at cycle M gives `pc_enable` = 0 from cycle M+1. `pipe_enable` falls at M+1+`DRAIN_CYCLES`.
- **Handshake:**
  - A byte transfers on any cycle with `tx_valid` && `tx_ready`.
  - `tx_data` stays stable while `tx_valid` && !`tx_ready`.
  - The next byte is presented on the following cycle, so back-to-back transfers are allowed.
  - `tx_valid` is never withdrawn without a transfer, except by reset.
- **Snapshot stability:** the shadow copy means later changes on `snap_data` never alter a frame in progress.

## Configuration
- Macro `DEBUG_SNAPSHOT_CHECKSUM_EN`.
- **Defined:** an extra final byte is sent, equal to the XOR of every preceding frame byte (`SOF` and count included).
- **Undefined:** no checksum byte and no checksum register. The frame ends after the last data byte.

## Structure
- Shared package `debug_snapshot_pkg` holds:
  - the state enum;
  - the command byte constants;
  - a frame-length function of `NUM_WORDS`, `WORD_W` and the checksum option.
- One sub-module, `debug_step_ctrl`: the HALT/RUN/STEP/DRAIN control and enable generation.
- The top level holds capture, byte sequencing and the handshake.

## Test plan
- **Reset:** reset, then 'd' with `NUM_WORDS`=2, words 32'h11223344 and 32'hAABBCCDD, `tx_ready`=1 → bytes A5 02 11 22 33 44 AA BB CC DD, plus E3 with checksum enabled; then `busy` = 0.
- **Backpressure:** same dump with `tx_ready` toggling every 3 cycles → identical byte sequence, no byte repeated or lost, `tx_data` stable while stalled.
- **Single step:** 's' at cycle 10 → enables high only in cycle 11, `tx_valid` at cycle 13, frame carries the snapshot sampled at cycle 12.
- **Run and drain:** 'c', then `halt_req` at cycle 50 with `DRAIN_CYCLES`=4 → `pc_enable` low from 51, `pipe_enable` low from 55, frame starts automatically.
- **Snapshot freeze and dropped commands:** change `snap_data` to 32'hFFFFFFFF during SEND and send 'c' mid-frame → frame unchanged, 'c' ignored, state HALT afterwards.
- **Reset mid-frame:** assert `reset` during byte 5 → `tx_valid` 0 that same cycle, state HALT, next 'd' yields a complete fresh frame.

Source files
------------

// File: rtl/debug_snapshot_pkg.sv
// Shared types for the debug snapshot unit: controller states, UART command
// bytes and the frame-length helper used to size the byte index.
package debug_snapshot_pkg;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_CAPTURE,
    ST_SEND
  } state_e;

  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

  // SOF + count + data bytes (+ checksum byte when enabled).
  function automatic int frame_len(input int num_words, input int word_w, input bit csum_en);
    return 2 + (num_words * word_w) / 8 + (csum_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/debug_step_ctrl.sv
// Halt/run/step/drain controller: owns the unit's state register and
// generates the registered pipeline and PC enables.
module debug_step_ctrl
  import debug_snapshot_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       halt_req,
  input  logic       frame_done,
  output state_e     state_q,
  output state_e     state_d,
  output logic       pipe_enable,
  output logic       pc_enable
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             pipe_enable_q, pipe_enable_d;
  logic             pc_enable_q, pc_enable_d;
  logic             cmd_run, cmd_halt, cmd_step, cmd_dump;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HALT;
      drain_cnt_q   <= '0;
      pipe_enable_q <= 1'b0;
      pc_enable_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      pipe_enable_q <= pipe_enable_d;
      pc_enable_q   <= pc_enable_d;
    end
  end

  // NOTE: every variable gets a default at the top of each always_comb so no
  // path through the case statement can infer a latch.
  always_comb begin
    cmd_run     = rx_valid && (rx_data == CMD_RUN);
    cmd_halt    = rx_valid && (rx_data == CMD_HALT);
    cmd_step    = rx_valid && (rx_data == CMD_STEP);
    cmd_dump    = rx_valid && (rx_data == CMD_DUMP);
    state_d     = state_q;
    drain_cnt_d = (state_q == ST_DRAIN) ? drain_cnt_q + 1'b1 : '0;
    case (state_q)
      ST_HALT: begin
        if (cmd_run)       state_d = ST_RUN;
        else if (cmd_step) state_d = ST_STEP;
        else if (cmd_dump) state_d = ST_CAPTURE;
      end
      ST_RUN: begin
        if (halt_req || cmd_halt) state_d = (DRAIN_CYCLES == 0) ? ST_CAPTURE : ST_DRAIN;
      end
      ST_STEP:    state_d = ST_CAPTURE;
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND: begin
        if (frame_done) state_d = ST_HALT;
      end
      default:    state_d = ST_HALT;
    endcase
  end

  // Enables are decoded from the next state so the registered copy lines up
  // with the state it belongs to.
  always_comb begin
    pipe_enable_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
    pc_enable_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
  end

  assign pipe_enable = pipe_enable_q;
  assign pc_enable   = pc_enable_q;

endmodule

// File: rtl/debug_snapshot_unit.sv
// Debug snapshot unit: command decode, shadow capture and framed byte output.
// Define DEBUG_SNAPSHOT_CHECKSUM_EN to append an XOR checksum byte to each frame.
module debug_snapshot_unit
  import debug_snapshot_pkg::*;
#(
  parameter int         NUM_WORDS    = 40,
  parameter int         WORD_W       = 32,
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [7:0] SOF          = 8'hA5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic [NUM_WORDS*WORD_W-1:0] snap_data,
  input  logic                        halt_req,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        pipe_enable,
  output logic                        pc_enable,
  output logic                        busy
);

`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int SNAP_W     = NUM_WORDS * WORD_W;
  localparam int DATA_BYTES = SNAP_W / 8;
  localparam int FRAME_LEN  = frame_len(NUM_WORDS, WORD_W, CSUM_EN);
  localparam int IDX_W      = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_END = IDX_W'(DATA_BYTES);

  state_e            state_q, state_d;
  logic              frame_done, xfer;
  logic [SNAP_W-1:0] snap_rev;
  logic [SNAP_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  debug_step_ctrl #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_step_ctrl (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .halt_req    (halt_req),
    .frame_done  (frame_done),
    .state_q     (state_q),
    .state_d     (state_d),
    .pipe_enable (pipe_enable),
    .pc_enable   (pc_enable)
  );

  // Word 0 is moved to the top so the stream is simply the shadow read out
  // MSB byte first, shifting left one byte per data byte.
  always_comb begin
    snap_rev = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      snap_rev[(NUM_WORDS-1-w)*WORD_W +: WORD_W] = snap_data[w*WORD_W +: WORD_W];
    end
  end

  // NOTE: the shadow register is wide but still reset, so a frame started
  // straight after reset can never expose stale contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    frame_done = 1'b0;
    xfer       = tx_valid_q && tx_ready;
    busy_d     = (state_d == ST_CAPTURE) || (state_d == ST_SEND);
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (state_q == ST_CAPTURE) begin
      shadow_d   = snap_rev;
      idx_d      = '0;
      tx_valid_d = 1'b1;
      tx_data_d  = SOF;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
      csum_d     = '0;
`endif
    end else if (state_q == ST_SEND && xfer) begin
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
      csum_d = csum_q ^ tx_data_q;
`endif
      if (idx_q == IDX_LAST) begin
        // Index holds at the last byte rather than stepping past the frame.
        frame_done = 1'b1;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '0) begin
          tx_data_d = 8'(NUM_WORDS);
        end else if (idx_q <= IDX_DATA_END) begin
          tx_data_d = shadow_q[SNAP_W-1 -: 8];
          shadow_d  = shadow_q << 8;
        end else begin
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
          tx_data_d = csum_q ^ tx_data_q;
`else
          tx_data_d = '0;
`endif
        end
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_debug_snapshot_unit.sv
// Directed bench for debug_snapshot_unit with two 32-bit words and a 4-cycle drain.
module tb_debug_snapshot_unit;
  import debug_snapshot_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [63:0] snap_data;
  logic        halt_req;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        pipe_enable;
  logic        pc_enable;
  logic        busy;

  int          tests_run;
  int          tests_failed;
  logic [7:0]  exp_b [0:15];
  int          exp_len;
  logic [7:0]  got [0:31];

  debug_snapshot_unit #(
    .NUM_WORDS    (2),
    .WORD_W       (32),
    .DRAIN_CYCLES (4),
    .SOF          (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .snap_data   (snap_data),
    .halt_req    (halt_req),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .pipe_enable (pipe_enable),
    .pc_enable   (pc_enable),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  // Expected frame for word0 = w0, word1 = w1.
  task automatic set_exp(input logic [31:0] w0, input logic [31:0] w1);
    logic [7:0] x;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      exp_b[2+i] = w0[31-8*i -: 8];
      exp_b[6+i] = w1[31-8*i -: 8];
    end
    exp_len = 10;
    x = 8'h00;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
    for (int i = 0; i < 10; i++) x = x ^ exp_b[i];
    exp_b[10] = x;
    exp_len = 11;
`endif
  endtask

  // Called at a negedge; returns at the negedge after rx_valid was high.
  task automatic send_cmd(input logic [7:0] c);
    rx_data  = c;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready toggles every 3 cycles.
  // poke_at: byte count at which snap_data is overwritten and 'c' is sent.
  // abort_at: byte count at which to return early.
  task automatic recv_frame(input int mode, input int poke_at, input int abort_at,
                            output int n, output int stab_err, output bit timeout);
    int         cyc;
    bit         prev_stall;
    bit         poked;
    logic [7:0] prev_data;
    n = 0; stab_err = 0; timeout = 1'b0; prev_stall = 1'b0; poked = 1'b0;
    prev_data = 8'h00; cyc = 0;
    for (int i = 0; i < 32; i++) got[i] = 8'hxx;
    while (n < exp_len && n != abort_at) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (cyc > 400) begin
        timeout = 1'b1;
        break;
      end
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stab_err++;
      tx_ready = (mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
      if (!poked && n == poke_at) begin
        snap_data = '1;
        rx_data   = CMD_RUN;
        rx_valid  = 1'b1;
        poked     = 1'b1;
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        got[n] = tx_data;
        n++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = (tx_valid === 1'b1);
      end
      prev_data = tx_data;
      cyc++;
    end
  endtask

  task automatic test_reset();
    int n, se; bit to;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; halt_req = 1'b0; tx_ready = 1'b0;
    snap_data = {32'hAABBCCDD, 32'h11223344};
    repeat (3) @(negedge clk);
    tests_run++; if (tx_valid !== 1'b0)    begin tests_failed++; $display("FAIL reset_tx_valid: got %b, expected 0", tx_valid); end
    tests_run++; if (tx_data !== 8'h00)    begin tests_failed++; $display("FAIL reset_tx_data: got %02h, expected 00", tx_data); end
    tests_run++; if (pipe_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_pipe_enable: got %b, expected 0", pipe_enable); end
    tests_run++; if (pc_enable !== 1'b0)   begin tests_failed++; $display("FAIL reset_pc_enable: got %b, expected 0", pc_enable); end
    tests_run++; if (busy !== 1'b0)        begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    send_cmd(CMD_DUMP);
    tests_run++; if (busy !== 1'b1 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_capture: busy=%b tx_valid=%b, expected busy=1 tx_valid=0", busy, tx_valid); end
    set_exp(32'h11223344, 32'hAABBCCDD);
    recv_frame(0, -1, -1, n, se, to);
    tests_run++; if (n !== exp_len || to) begin tests_failed++; $display("FAIL reset_dump_len: got %0d bytes (timeout=%0b), expected %0d", n, to, exp_len); end
    for (int i = 0; i < exp_len; i++) begin
      tests_run++; if (got[i] !== exp_b[i]) begin tests_failed++; $display("FAIL reset_dump_byte[%0d]: got %02h, expected %02h", i, got[i], exp_b[i]); end
    end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dump_end: busy=%b tx_valid=%b, expected 0 0", busy, tx_valid); end
  endtask

  task automatic test_halt_ignores();
    send_cmd(CMD_HALT);
    tests_run++; if (pipe_enable !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL halt_h_ignored: pipe=%b busy=%b, expected 0 0", pipe_enable, busy); end
    send_cmd(8'h78);
    tests_run++; if (pipe_enable !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL halt_unknown_ignored: pipe=%b busy=%b, expected 0 0", pipe_enable, busy); end
  endtask

  task automatic test_backpressure();
    int n, se; bit to;
    tx_ready = 1'b0;
    snap_data = {32'hAABBCCDD, 32'h11223344};
    set_exp(32'h11223344, 32'hAABBCCDD);
    send_cmd(CMD_DUMP);
    recv_frame(1, -1, -1, n, se, to);
    tests_run++; if (n !== exp_len || to) begin tests_failed++; $display("FAIL bp_len: got %0d bytes (timeout=%0b), expected %0d", n, to, exp_len); end
    tests_run++; if (se !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable stalls, expected 0", se); end
    for (int i = 0; i < exp_len; i++) begin
      tests_run++; if (got[i] !== exp_b[i]) begin tests_failed++; $display("FAIL bp_byte[%0d]: got %02h, expected %02h", i, got[i], exp_b[i]); end
    end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_end: busy=%b tx_valid=%b, expected 0 0", busy, tx_valid); end
  endtask

  task automatic test_single_step();
    int n, se; bit to;
    tx_ready = 1'b0;
    snap_data = {32'hCAFEF00D, 32'h0BADBEEF};
    set_exp(32'h01234567, 32'h89ABCDEF);
    send_cmd(CMD_STEP);
    tests_run++; if (pipe_enable !== 1'b1 || pc_enable !== 1'b1) begin tests_failed++; $display("FAIL step_n1_enables: pipe=%b pc=%b, expected 1 1", pipe_enable, pc_enable); end
    @(negedge clk);
    snap_data = {32'h89ABCDEF, 32'h01234567};
    tests_run++; if (pipe_enable !== 1'b0 || pc_enable !== 1'b0) begin tests_failed++; $display("FAIL step_n2_enables: pipe=%b pc=%b, expected 0 0", pipe_enable, pc_enable); end
    tests_run++; if (busy !== 1'b1 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL step_n2_capture: busy=%b tx_valid=%b, expected 1 0", busy, tx_valid); end
    @(negedge clk);
    snap_data = {32'hDEADBEEF, 32'hDEADBEEF};
    tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin tests_failed++; $display("FAIL step_n3_sof: tx_valid=%b tx_data=%02h, expected 1 a5", tx_valid, tx_data); end
    recv_frame(0, -1, -1, n, se, to);
    tests_run++; if (n !== exp_len || to) begin tests_failed++; $display("FAIL step_len: got %0d bytes (timeout=%0b), expected %0d", n, to, exp_len); end
    for (int i = 0; i < exp_len; i++) begin
      tests_run++; if (got[i] !== exp_b[i]) begin tests_failed++; $display("FAIL step_byte[%0d]: got %02h, expected %02h", i, got[i], exp_b[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_run_drain();
    int n, se; bit to;
    tx_ready = 1'b0;
    snap_data = {32'h13579BDF, 32'h2468ACE0};
    set_exp(32'h2468ACE0, 32'h13579BDF);
    send_cmd(CMD_RUN);
    tests_run++; if (pipe_enable !== 1'b1 || pc_enable !== 1'b1) begin tests_failed++; $display("FAIL run_enables: pipe=%b pc=%b, expected 1 1", pipe_enable, pc_enable); end
    repeat (3) @(negedge clk);
    tests_run++; if (pipe_enable !== 1'b1 || pc_enable !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL run_hold: pipe=%b pc=%b busy=%b, expected 1 1 0", pipe_enable, pc_enable, busy); end
    halt_req = 1'b1;
    rx_data  = CMD_HALT;
    rx_valid = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    rx_valid = 1'b0;
    tests_run++; if (pc_enable !== 1'b0 || pipe_enable !== 1'b1) begin tests_failed++; $display("FAIL drain_m1: pc=%b pipe=%b, expected 0 1", pc_enable, pipe_enable); end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      tests_run++; if (pipe_enable !== 1'b1 || pc_enable !== 1'b0) begin tests_failed++; $display("FAIL drain_m%0d: pipe=%b pc=%b, expected 1 0", k, pipe_enable, pc_enable); end
    end
    @(negedge clk);
    tests_run++; if (pipe_enable !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL drain_m5: pipe=%b busy=%b, expected 0 1", pipe_enable, busy); end
    recv_frame(0, -1, -1, n, se, to);
    tests_run++; if (n !== exp_len || to) begin tests_failed++; $display("FAIL drain_len: got %0d bytes (timeout=%0b), expected %0d", n, to, exp_len); end
    for (int i = 0; i < exp_len; i++) begin
      tests_run++; if (got[i] !== exp_b[i]) begin tests_failed++; $display("FAIL drain_byte[%0d]: got %02h, expected %02h", i, got[i], exp_b[i]); end
    end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || pipe_enable !== 1'b0) begin tests_failed++; $display("FAIL drain_end: busy=%b pipe=%b, expected 0 0", busy, pipe_enable); end
  endtask

  task automatic test_freeze_and_drop();
    int n, se; bit to;
    tx_ready = 1'b0;
    snap_data = {32'h4B5A6978, 32'h0F1E2D3C};
    set_exp(32'h0F1E2D3C, 32'h4B5A6978);
    send_cmd(CMD_DUMP);
    recv_frame(1, 4, -1, n, se, to);
    tests_run++; if (n !== exp_len || to) begin tests_failed++; $display("FAIL freeze_len: got %0d bytes (timeout=%0b), expected %0d", n, to, exp_len); end
    for (int i = 0; i < exp_len; i++) begin
      tests_run++; if (got[i] !== exp_b[i]) begin tests_failed++; $display("FAIL freeze_byte[%0d]: got %02h, expected %02h", i, got[i], exp_b[i]); end
    end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL freeze_end: busy=%b tx_valid=%b, expected 0 0", busy, tx_valid); end
    @(negedge clk);
    tests_run++; if (pipe_enable !== 1'b0 || pc_enable !== 1'b0) begin tests_failed++; $display("FAIL drop_c: pipe=%b pc=%b, expected 0 0", pipe_enable, pc_enable); end
  endtask

  task automatic test_reset_mid_frame();
    int n, se; bit to;
    tx_ready = 1'b0;
    snap_data = {32'hAABBCCDD, 32'h11223344};
    set_exp(32'h11223344, 32'hAABBCCDD);
    send_cmd(CMD_DUMP);
    recv_frame(0, -1, 5, n, se, to);
    @(posedge clk);
    #2;
    tests_run++; if (tx_valid !== 1'b1 || tx_data !== exp_b[5]) begin tests_failed++; $display("FAIL midreset_byte5: tx_valid=%b tx_data=%02h, expected 1 %02h", tx_valid, tx_data, exp_b[5]); end
    reset = 1'b1;
    #1;
    tests_run++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_clear: tx_valid=%b tx_data=%02h busy=%b, expected 0 00 0", tx_valid, tx_data, busy); end
    @(negedge clk);
    reset = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || pipe_enable !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_halt: busy=%b pipe=%b tx_valid=%b, expected 0 0 0", busy, pipe_enable, tx_valid); end
    send_cmd(CMD_DUMP);
    recv_frame(0, -1, -1, n, se, to);
    tests_run++; if (n !== exp_len || to) begin tests_failed++; $display("FAIL midreset_len: got %0d bytes (timeout=%0b), expected %0d", n, to, exp_len); end
    for (int i = 0; i < exp_len; i++) begin
      tests_run++; if (got[i] !== exp_b[i]) begin tests_failed++; $display("FAIL midreset_byte[%0d]: got %02h, expected %02h", i, got[i], exp_b[i]); end
    end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_end: busy=%b tx_valid=%b, expected 0 0", busy, tx_valid); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_halt_ignores();
    test_backpressure();
    test_single_step();
    test_run_drain();
    test_freeze_and_drop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
